// File: rtl/stepper_pkg.sv
// stepper_pkg
//   Shared definitions for the stepper phase driver: FSM state encoding,
//   JA bit positions, and the coil phase table with its length and index width.
//   Build option: define HALF_STEP_EN to select the 8-entry half-step table;
//   when it is left undefined, the 4-entry full-step table is used.
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam int JA_EN  = 4;
    localparam int JA_DIR = 5;

`ifdef HALF_STEP_EN
    localparam int PHASE_LEN = 8;
    localparam int PH_W      = 3;
`else
    localparam int PHASE_LEN = 4;
    localparam int PH_W      = 2;
`endif

    typedef logic [PH_W-1:0] phase_t;

`ifdef HALF_STEP_EN
    function automatic logic [3:0] phase_pattern(input phase_t idx);
        logic [3:0] pat;
        case (idx)
            3'd0:    pat = 4'b0001;
            3'd1:    pat = 4'b0011;
            3'd2:    pat = 4'b0010;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0100;
            3'd5:    pat = 4'b1100;
            3'd6:    pat = 4'b1000;
            3'd7:    pat = 4'b1001;
            default: pat = 4'b0000;
        endcase
        return pat;
    endfunction
`else
    function automatic logic [3:0] phase_pattern(input phase_t idx);
        logic [3:0] pat;
        case (idx)
            2'd0:    pat = 4'b0011;
            2'd1:    pat = 4'b0110;
            2'd2:    pat = 4'b1100;
            2'd3:    pat = 4'b1001;
            default: pat = 4'b0000;
        endcase
        return pat;
    endfunction
`endif

    // Energised JA word: direction, driver enable, and the coil pattern.
    function automatic logic [5:0] ja_word(input logic dir, input phase_t idx);
        logic [5:0] w;
        w         = '0;
        w[3:0]    = phase_pattern(idx);
        w[JA_EN]  = 1'b1;
        w[JA_DIR] = dir;
        return w;
    endfunction

endpackage

// File: rtl/stepper_phase_driver_debouncer.sv
// input_debouncer
//   Brings an asynchronous input into the clock domain through a 2-FF
//   synchroniser. The debounced output only follows the synchronised value
//   after that value has differed from the output for DEBOUNCE_CYC
//   consecutive cycles.
// Ports
//   clock  in   system clock
//   reset  in   asynchronous active-low reset
//   din    in   raw asynchronous input
//   dout   out  debounced, synchronous output (0 after reset)
module input_debouncer #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
            // Terminal count: the input has been stable long enough.
            deb_d = sync2_q;
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= RELOAD;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = deb_q;

endmodule

// File: rtl/stepper_phase_driver.sv
// stepper_phase_driver
//   Peripheral side of the JA stepper port. A command (direction, step count,
//   step period) is taken over a valid/ready handshake. The coil phases are
//   then sequenced on JA at the commanded rate while absolute position is
//   tracked. Moves toward home stop on the debounced limit switch.
//   Build option: HALF_STEP_EN selects the 8-entry half-step phase table.
// Ports
//   clock, reset       system clock, asynchronous active-low reset
//   cmd_valid/ready    command handshake (ready only in IDLE)
//   cmd_dir            1 = forward (+1), 0 = toward home (-1)
//   cmd_steps          steps to take
//   cmd_period         clock cycles per step (< 2 selects DEFAULT_PERIOD)
//   abort              stop the current move
//   limit_switch       raw asynchronous home limit switch
//   JA                 [3:0] coil phases, [4] driver enable, [5] direction
//   busy, done         move in progress / one-cycle end-of-command pulse
//   hit_limit          sticky limit flag, cleared on the next accept
//   steps_done         steps taken in the current or last move
//   position           signed absolute position, 0 = home
//
//   state | meaning
//   IDLE  | waiting for a command, coils off
//   RUN   | stepping at the latched period
//   FIN   | one-cycle done pulse, coils off, then back to IDLE
module stepper_phase_driver
    import stepper_pkg::*;
#(
    parameter int STEP_W         = 16,
    parameter int PER_W          = 20,
    parameter int DEFAULT_PERIOD = 50000,
    parameter int DEBOUNCE_CYC   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [PER_W-1:0]  cmd_period,
    input  logic              abort,
    input  logic              limit_switch,
    output logic [5:0]        JA,
    output logic              busy,
    output logic              done,
    output logic              hit_limit,
    output logic [STEP_W-1:0] steps_done,
    output logic [STEP_W-1:0] position
);

    localparam logic [PER_W-1:0] DEF_P = PER_W'(DEFAULT_PERIOD);

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic [PER_W-1:0]  cnt_q, cnt_d;
    phase_t            phase_q, phase_d;
    logic [5:0]        ja_q, ja_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hit_q, hit_d;
    logic              ready_q, ready_d;
    logic [STEP_W-1:0] sd_q, sd_d;
    logic [STEP_W-1:0] pos_q, pos_d;
    logic              lim_deb;

    input_debouncer #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_limit_deb (
        .clock(clock),
        .reset(reset),
        .din  (limit_switch),
        .dout (lim_deb)
    );

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        steps_d  = steps_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        ja_d     = ja_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hit_d    = hit_q;
        sd_d     = sd_q;
        pos_d    = pos_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    dir_d    = cmd_dir;
                    steps_d  = cmd_steps;
                    period_d = (cmd_period < PER_W'(2)) ? DEF_P : cmd_period;
                    cnt_d    = period_d - PER_W'(1);
                    sd_d     = '0;
                    hit_d    = 1'b0;
                    if (!cmd_dir && lim_deb) begin
                        // Already at home: no motion, report the limit.
                        hit_d   = 1'b1;
                        pos_d   = '0;
                        state_d = ST_FIN;
                    end else if (cmd_steps == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        busy_d  = 1'b1;
                        ja_d    = ja_word(cmd_dir, phase_q);
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                // Limit beats abort beats the step tick.
                if (lim_deb && !dir_q) begin
                    pos_d   = '0;
                    hit_d   = 1'b1;
                    state_d = ST_FIN;
                end else if (abort) begin
                    state_d = ST_FIN;
                end else if (cnt_q == '0) begin
                    cnt_d   = period_q - PER_W'(1);
                    phase_d = dir_q ? phase_q + phase_t'(1) : phase_q - phase_t'(1);
                    sd_d    = sd_q + STEP_W'(1);
                    pos_d   = dir_q ? pos_q + STEP_W'(1) : pos_q - STEP_W'(1);
                    ja_d    = ja_word(dir_q, phase_d);
                    if (sd_d == steps_q) begin
                        state_d = ST_FIN;
                    end
                end else begin
                    cnt_d = cnt_q - PER_W'(1);
                end
            end

            ST_FIN: begin
                // The last step pattern stays visible for one cycle and drops here.
                done_d  = 1'b1;
                busy_d  = 1'b0;
                ja_d    = '0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                ja_d    = '0;
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            dir_q    <= 1'b0;
            steps_q  <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= '0;
            ja_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hit_q    <= 1'b0;
            ready_q  <= 1'b1;
            sd_q     <= '0;
            pos_q    <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            steps_q  <= steps_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            ja_q     <= ja_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hit_q    <= hit_d;
            ready_q  <= ready_d;
            sd_q     <= sd_d;
            pos_q    <= pos_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign JA         = ja_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign hit_limit  = hit_q;
    assign steps_done = sd_q;
    assign position   = pos_q;

endmodule

// File: tb/tb_stepper_phase_driver.sv
// Testbench for stepper_phase_driver. Uses a short DEFAULT_PERIOD so the
// default-period path completes quickly.
module tb_stepper_phase_driver;

    localparam int STEP_W = 16;
    localparam int PER_W  = 20;
    localparam int DEF    = 40;
    localparam int DEB    = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_dir = 1'b0;
    logic [STEP_W-1:0] cmd_steps = '0;
    logic [PER_W-1:0]  cmd_period = '0;
    logic              abort = 1'b0;
    logic              limit_switch = 1'b0;
    logic              cmd_ready;
    logic [5:0]        JA;
    logic              busy;
    logic              done;
    logic              hit_limit;
    logic [STEP_W-1:0] steps_done;
    logic [STEP_W-1:0] position;

    stepper_phase_driver #(
        .STEP_W(STEP_W), .PER_W(PER_W), .DEFAULT_PERIOD(DEF), .DEBOUNCE_CYC(DEB)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
        .limit_switch(limit_switch), .JA(JA), .busy(busy), .done(done),
        .hit_limit(hit_limit), .steps_done(steps_done), .position(position)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int mdl_pos = 0;
    int mdl_phase = 0;
    int plen;
    logic [3:0] pat [8];

    typedef struct {
        bit dir;
        int steps;
        int period;
        int abort_tick;
        bit hold;
        int sd;
        int lat;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wrapph(input int p);
        return ((p % plen) + plen) % plen;
    endfunction

    // Runs one command and checks it cycle by cycle against a transaction-level
    // model: step k lands k*eff cycles after accept, done one cycle after the
    // last step (or after the abort tick), coils off from done onwards.
    // lim = limit switch held (and already debounced) for the whole move.
    task automatic do_move(input bit dir, input int steps, input int period,
                           input int abort_tick, input bit hold, input bit lim,
                           input bit use_tbl, input int tbl_sd, input int tbl_lat);
        int eff, taken, done_c, done_seen, done_cnt, k, ph, exp_sd, exp_lat;
        bit exp_hit, moving;
        logic [5:0] exp_ja;
        logic exp_busy;
        eff = (period < 2) ? DEF : period;
        exp_hit = 1'b0;
        moving = 1'b0;
        if (lim && !dir) begin
            taken = 0; done_c = 1; exp_hit = 1'b1;
        end else if (steps == 0) begin
            taken = 0; done_c = 1;
        end else if (abort_tick > 0 && abort_tick <= steps) begin
            taken = abort_tick - 1; done_c = abort_tick * eff + 1; moving = 1'b1;
        end else begin
            taken = steps; done_c = steps * eff + 1; moving = 1'b1;
        end
        exp_sd  = use_tbl ? tbl_sd : taken;
        exp_lat = use_tbl ? tbl_lat : done_c;

        check("ready_before", 32'(cmd_ready), 32'd1);
        @(negedge clock);
        cmd_dir = dir; cmd_steps = STEP_W'(steps); cmd_period = PER_W'(period);
        cmd_valid = 1'b1;
        @(posedge clock);
        done_seen = -1; done_cnt = 0;
        for (int c = 1; c <= done_c + 2; c++) begin
            @(negedge clock);
            cmd_valid = hold && (c <= done_c);
            abort = (abort_tick > 0) && (c == abort_tick * eff);
            @(posedge clock);
            #1;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_seen < 0) done_seen = c;
            end
            if (moving && c < done_c) begin
                k = c / eff;
                if (k > taken) k = taken;
                ph = wrapph(dir ? mdl_phase + k : mdl_phase - k);
                exp_ja = {dir, 1'b1, pat[ph]};
                exp_busy = 1'b1;
            end else begin
                exp_ja = 6'd0;
                exp_busy = 1'b0;
            end
            check("ja", 32'(JA), 32'(exp_ja));
            check("busy", 32'(busy), 32'(exp_busy));
            check("ready", 32'(cmd_ready), 32'(c >= done_c));
        end
        abort = 1'b0;
        cmd_valid = 1'b0;
        if (exp_hit) mdl_pos = 0;
        else mdl_pos = dir ? mdl_pos + taken : mdl_pos - taken;
        mdl_phase = wrapph(dir ? mdl_phase + taken : mdl_phase - taken);
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_latency", 32'(done_seen), 32'(exp_lat));
        check("steps_done", 32'(steps_done), 32'(exp_sd));
        check("position", 32'(position), 32'(mdl_pos[15:0]));
        check("hit_limit", 32'(hit_limit), 32'(exp_hit));
    endtask

    initial begin
        int done_seen, done_cnt;
`ifdef HALF_STEP_EN
        plen = 8;
        pat[0] = 4'b0001; pat[1] = 4'b0011; pat[2] = 4'b0010; pat[3] = 4'b0110;
        pat[4] = 4'b0100; pat[5] = 4'b1100; pat[6] = 4'b1000; pat[7] = 4'b1001;
`else
        plen = 4;
        pat[0] = 4'b0011; pat[1] = 4'b0110; pat[2] = 4'b1100; pat[3] = 4'b1001;
        pat[4] = 4'b0000; pat[5] = 4'b0000; pat[6] = 4'b0000; pat[7] = 4'b0000;
`endif
        //               dir steps per abort hold  sd  lat
        tbl[0] = '{1'b1,  5,  4,  0, 1'b0,  5,  21};
        tbl[1] = '{1'b1, 50,  8, 10, 1'b0,  9,  81};
        tbl[2] = '{1'b0,  0,  3,  0, 1'b0,  0,   1};
        tbl[3] = '{1'b1,  3,  2,  0, 1'b1,  3,   7};
        tbl[4] = '{1'b0,  6,  3,  0, 1'b0,  6,  19};
        tbl[5] = '{1'b1,  2,  1,  0, 1'b0,  2,  81};
        tbl[6] = '{1'b0,  1,  0,  0, 1'b0,  1,  41};
        tbl[7] = '{1'b1,  4,  7,  2, 1'b0,  1,  15};
        tbl[8] = '{1'b1,  9,  2,  0, 1'b0,  9,  19};
        tbl[9] = '{1'b0,  9,  2,  0, 1'b0,  9,  19};

        // Reset state while held in reset.
        repeat (3) @(posedge clock);
        #1;
        check("rst_ja", 32'(JA), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_pos", 32'(position), 32'd0);
        check("rst_sd", 32'(steps_done), 32'd0);
        check("rst_hit", 32'(hit_limit), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        for (int i = 0; i < 10; i++) begin
            do_move(tbl[i].dir, tbl[i].steps, tbl[i].period, tbl[i].abort_tick,
                    tbl[i].hold, 1'b0, 1'b1, tbl[i].sd, tbl[i].lat);
        end

        for (int i = 0; i < 12; i++) begin
            int st, pr, ab;
            bit dr, hd;
            dr = 1'($urandom_range(0, 1));
            st = $urandom_range(0, 9);
            pr = $urandom_range(0, 6);
            hd = 1'($urandom_range(0, 1));
            ab = (st > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, st) : 0;
            do_move(dr, st, pr, ab, hd, 1'b0, 1'b0, 0, 0);
        end

        // Reset in the middle of a move: outputs drop without a clock edge.
        @(negedge clock);
        cmd_dir = 1'b1; cmd_steps = STEP_W'(20); cmd_period = PER_W'(2); cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        check("pre_reset_pos", 32'(position), 32'(16'(mdl_pos + 4)));
        #1;
        reset = 1'b0;
        #1;
        check("async_ja", 32'(JA), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_ready", 32'(cmd_ready), 32'd1);
        check("async_pos", 32'(position), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_sd", 32'(steps_done), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        mdl_pos = 0;
        mdl_phase = 0;
        @(posedge clock);
        #1;

        // Limit hit while homing: get to position 7, home from there.
        do_move(1'b1, 7, 2, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        @(negedge clock);
        cmd_dir = 1'b0; cmd_steps = STEP_W'(100); cmd_period = PER_W'(10); cmd_valid = 1'b1;
        @(posedge clock);
        done_seen = -1; done_cnt = 0;
        for (int c = 1; c <= 75; c++) begin
            @(negedge clock);
            cmd_valid = 1'b0;
            if (c == 31) limit_switch = 1'b1;
            if (c == 51) limit_switch = 1'b0;
            @(posedge clock);
            #1;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_seen < 0) done_seen = c;
            end
        end
        check("lim_done_count", 32'(done_cnt), 32'd1);
        check("lim_latency_ok", 32'(done_seen > 0 && (done_seen - 1 - 30) <= DEB + 3), 32'd1);
        check("lim_steps_done", 32'(steps_done), 32'd4);
        check("lim_position", 32'(position), 32'd0);
        check("lim_hit", 32'(hit_limit), 32'd1);
        check("lim_ja", 32'(JA), 32'd0);
        mdl_pos = 0;
        mdl_phase = wrapph(mdl_phase - 4);
        repeat (DEB + 6) @(posedge clock);
        #1;

        // Limit held and debounced: forward ignores it, homing stops at once.
        @(negedge clock);
        limit_switch = 1'b1;
        repeat (DEB + 6) @(posedge clock);
        #1;
        do_move(1'b1, 3, 2, 0, 1'b0, 1'b1, 1'b0, 0, 0);
        do_move(1'b0, 5, 3, 0, 1'b0, 1'b1, 1'b0, 0, 0);
        do_move(1'b1, 2, 3, 0, 1'b0, 1'b1, 1'b0, 0, 0);
        @(negedge clock);
        limit_switch = 1'b0;
        repeat (DEB + 6) @(posedge clock);
        #1;
        do_move(1'b0, 3, 2, 0, 1'b0, 1'b0, 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
